regfile_ctrl: RTL and testbench

Command sequencer for the 4×8-bit register file. It accepts one register-transfer command at a time over a valid/ready handshake and expands it into a fixed multi-cycle sequence of register-file control signals: write address, write enable, read address, tristate enable and write data. Read results come back on a valid/ready response port. It sits beside `register_file` in the datapath top, and all register-file controls are driven only by this block.

---
 rtl/regfile_ctrl_pkg.sv | 25 ++
 rtl/regfile_ctrl_if.sv | 47 ++++
 rtl/regfile_ctrl.sv | 153 +++++++++++++++
 tb/tb_regfile_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file command sequencer: opcodes, sequencer
// states and default datapath geometry.
package regfile_ctrl_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 2;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_MOV = 2'b01,
        OP_SWP = 2'b10,
        OP_RD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_W_IMM = 3'd1,
        S_R_A   = 3'd2,
        S_R_B   = 3'd3,
        S_W_A   = 3'd4,
        S_W_B   = 3'd5,
        S_RSP   = 3'd6
    } state_e;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Command, response and register-file control bundle of regfile_ctrl.
// The slave modport is the controller's view; master is the environment's.
interface regfile_ctrl_if
    import regfile_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic [DW-1:0] cmd_imm;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    logic [AW-1:0] rf_a_write;
    logic          rf_en_decode;
    logic          rf_crw;
    logic [DW-1:0] rf_din;
    logic [AW-1:0] rf_a_read;
    logic          rf_en_tri;
    logic [DW-1:0] rf_dout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm,
        output cmd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output rf_a_write, rf_en_decode, rf_crw, rf_din, rf_a_read, rf_en_tri,
        input  rf_dout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm,
        input  cmd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  rf_a_write, rf_en_decode, rf_crw, rf_din, rf_a_read, rf_en_tri,
        output rf_dout
    );

endinterface

// File: rtl/regfile_ctrl.sv
// Expands LDI/MOV/SWP/RD commands into fixed register-file control sequences.
// Every output is a flop whose next value is decoded from the next state.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    regfile_ctrl_if.slave bus
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rs_q, rs_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] tmp_a_q, tmp_a_d;
    logic [DW-1:0] tmp_b_q, tmp_b_d;

    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [AW-1:0] rf_a_write_q, rf_a_write_d;
    logic          rf_en_decode_q, rf_en_decode_d;
    logic [DW-1:0] rf_din_q, rf_din_d;
    logic [AW-1:0] rf_a_read_q, rf_a_read_d;
    logic          rf_en_tri_q, rf_en_tri_d;

    // Sequencing and field latching
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        imm_d   = imm_q;
        tmp_a_d = tmp_a_q;
        tmp_b_d = tmp_b_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = op_e'(bus.cmd_op);
                    rd_d    = bus.cmd_rd;
                    rs_d    = bus.cmd_rs;
                    imm_d   = bus.cmd_imm;
                    state_d = (op_e'(bus.cmd_op) == OP_LDI) ? S_W_IMM : S_R_A;
                end
            end
            S_W_IMM: state_d = S_IDLE;
            S_R_A: begin
                tmp_a_d = bus.rf_dout;
                case (op_q)
                    OP_SWP:  state_d = S_R_B;
                    OP_MOV:  state_d = S_W_A;
                    default: state_d = S_RSP;
                endcase
            end
            S_R_B: begin
                tmp_b_d = bus.rf_dout;
                state_d = S_W_A;
            end
            S_W_A:   state_d = (op_q == OP_SWP) ? S_W_B : S_IDLE;
            S_W_B:   state_d = S_IDLE;
            S_RSP:   state_d = bus.rsp_ready ? S_IDLE : S_RSP;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so each output flop lines up with its state
    always_comb begin
        cmd_ready_d    = (state_d == S_IDLE);
        rsp_valid_d    = (state_d == S_RSP);
        rf_a_write_d   = '0;
        rf_en_decode_d = 1'b0;
        rf_din_d       = '0;
        rf_a_read_d    = '0;
        rf_en_tri_d    = 1'b0;

        case (state_d)
            S_W_IMM: begin
                rf_a_write_d   = rd_d;
                rf_en_decode_d = 1'b1;
                rf_din_d       = imm_d;
            end
            S_R_A: begin
                rf_a_read_d = rs_d;
                rf_en_tri_d = 1'b1;
            end
            S_R_B: begin
                rf_a_read_d = rd_d;
                rf_en_tri_d = 1'b1;
            end
            S_W_A: begin
                rf_a_write_d   = rd_d;
                rf_en_decode_d = 1'b1;
                rf_din_d       = tmp_a_d;
            end
            S_W_B: begin
                rf_a_write_d   = rs_d;
                rf_en_decode_d = 1'b1;
                rf_din_d       = tmp_b_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q        <= S_IDLE;
            op_q           <= OP_LDI;
            rd_q           <= '0;
            rs_q           <= '0;
            imm_q          <= '0;
            tmp_a_q        <= '0;
            tmp_b_q        <= '0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rf_a_write_q   <= '0;
            rf_en_decode_q <= 1'b0;
            rf_din_q       <= '0;
            rf_a_read_q    <= '0;
            rf_en_tri_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            rd_q           <= rd_d;
            rs_q           <= rs_d;
            imm_q          <= imm_d;
            tmp_a_q        <= tmp_a_d;
            tmp_b_q        <= tmp_b_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rf_a_write_q   <= rf_a_write_d;
            rf_en_decode_q <= rf_en_decode_d;
            rf_din_q       <= rf_din_d;
            rf_a_read_q    <= rf_a_read_d;
            rf_en_tri_q    <= rf_en_tri_d;
        end
    end

    // tmp_a is frozen while in RSP, so it doubles as the held response data
    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = tmp_a_q;
    assign bus.rf_a_write   = rf_a_write_q;
    assign bus.rf_en_decode = rf_en_decode_q;
    assign bus.rf_crw       = rf_en_decode_q;
    assign bus.rf_din       = rf_din_q;
    assign bus.rf_a_read    = rf_a_read_q;
    assign bus.rf_en_tri    = rf_en_tri_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: a behavioural 4x8 register file sits on the rf_* bus,
// and RD results are checked against an expected-data queue.
module tb_regfile_ctrl;
    import regfile_ctrl_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    regfile_ctrl_if #(.DW(8), .AW(2)) bus ();

    regfile_ctrl #(.DW(8), .AW(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int write_cnt   = 0;
    logic [1:0] last_waddr = 2'd0;
    logic [7:0] sb_q[$];

    // Behavioural register file
    logic [7:0] regs [4];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rf_crw && bus.rf_en_decode) begin
            regs[bus.rf_a_write] <= bus.rf_din;
            write_cnt  <= write_cnt + 1;
            last_waddr <= bus.rf_a_write;
        end
    end
    assign bus.rf_dout = bus.rf_en_tri ? regs[bus.rf_a_read] : 8'h00;

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic [7:0] imm, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs    = rs;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: cmd_ready=%b after 50 cycles, required 1", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [7:0] data, output int lat);
        int acc;
        int n;
        bus.rsp_ready = 1'b1;
        send_cmd(OP_RD, 2'd0, addr, 8'h00, acc);
        n = 0;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: rsp_valid=%b after 50 cycles, required 1", bus.rsp_valid);
            data = 8'hxx;
            lat = -1;
            return;
        end
        lat  = cyc - acc;
        data = bus.rsp_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] obs;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_rd    = 2'd0;
        bus.cmd_rs    = 2'd0;
        bus.cmd_imm   = 8'h00;
        bus.rsp_ready = 1'b1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready: got %b, required 1", bus.cmd_ready);
        end
        obs = {bus.rsp_valid, bus.rf_crw, bus.rf_en_decode, bus.rf_en_tri,
               bus.rf_a_write, bus.rf_a_read, bus.rf_din, bus.rsp_data, 1'b0};
        vectors++;
        if (obs !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", obs);
        end
    endtask

    task automatic test_ldi_rd();
        int acc, lat, wc0;
        logic [7:0] got, exp;
        wc0 = write_cnt;
        send_cmd(OP_LDI, 2'd2, 2'd0, 8'hA5, acc);
        repeat (3) @(negedge clk);
        vectors++;
        if (write_cnt - wc0 !== 1 || last_waddr !== 2'd2) begin
            miscompares++;
            $display("FAIL ldi_write_strobe: cycles=%0d addr=%0d, required 1 cycle addr 2",
                     write_cnt - wc0, last_waddr);
        end
        sb_q.push_back(8'hA5);
        read_reg(2'd2, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ldi_rd_data: got %h, required %h", got, exp);
        end
        // Acceptance edge is cycle 1; rsp_valid shows after the second edge
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL rd_latency: rsp_valid %0d edges after accept edge, required 1", lat);
        end
    endtask

    task automatic test_mov();
        int acc, lat;
        logic [7:0] got, exp;
        send_cmd(OP_LDI, 2'd0, 2'd0, 8'h3C, acc);
        send_cmd(OP_MOV, 2'd3, 2'd0, 8'hFF, acc);
        sb_q.push_back(8'h3C);
        read_reg(2'd3, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL mov_dst: R3 got %h, required %h", got, exp);
        end
        sb_q.push_back(8'h3C);
        read_reg(2'd0, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL mov_src: R0 got %h, required %h", got, exp);
        end
    endtask

    task automatic test_swp();
        int acc, lat, busy;
        logic [7:0] got, exp;
        send_cmd(OP_LDI, 2'd1, 2'd0, 8'h11, acc);
        send_cmd(OP_LDI, 2'd2, 2'd0, 8'h22, acc);
        send_cmd(OP_SWP, 2'd1, 2'd2, 8'h00, acc);
        busy = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        vectors++;
        if (busy !== 4) begin
            miscompares++;
            $display("FAIL swp_busy: cmd_ready low %0d cycles, required 4", busy);
        end
        sb_q.push_back(8'h22);
        sb_q.push_back(8'h11);
        read_reg(2'd1, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL swp_r1: got %h, required %h", got, exp);
        end
        read_reg(2'd2, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL swp_r2: got %h, required %h", got, exp);
        end
        send_cmd(OP_SWP, 2'd1, 2'd1, 8'h00, acc);
        sb_q.push_back(8'h22);
        read_reg(2'd1, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL swp_same: R1 got %h, required %h", got, exp);
        end
    endtask

    task automatic test_backpressure();
        int acc, n, wc0, lat;
        logic [7:0] held, exp, got;
        send_cmd(OP_LDI, 2'd3, 2'd0, 8'h5A, acc);
        bus.rsp_ready = 1'b0;
        sb_q.push_back(8'h5A);
        send_cmd(OP_RD, 2'd0, 2'd3, 8'h00, acc);
        n = 0;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = bus.rsp_data;
        wc0 = write_cnt;
        bus.cmd_op    = OP_LDI;
        bus.cmd_rd    = 2'd0;
        bus.cmd_rs    = 2'd0;
        bus.cmd_imm   = 8'h77;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.cmd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h ready=%b, required 1 %h 0",
                         i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, held);
            end
        end
        exp = sb_q.pop_front();
        vectors++;
        if (held !== exp) begin
            miscompares++;
            $display("FAIL stall_data: got %h, required %h", held, exp);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (write_cnt !== wc0) begin
            miscompares++;
            $display("FAIL stall_accept: %0d writes during stall, required 0", write_cnt - wc0);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.rf_crw !== 1'b1 || bus.rf_din !== 8'h77) begin
            miscompares++;
            $display("FAIL post_stall_accept: crw=%b din=%h, required 1 77", bus.rf_crw, bus.rf_din);
        end
        sb_q.push_back(8'h77);
        read_reg(2'd0, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL post_stall_r0: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_throughput();
        logic [7:0] imms [4];
        int acc_cyc [4];
        int idx, lat;
        logic rdy;
        logic [7:0] got, exp;
        imms[0] = 8'h81; imms[1] = 8'h42; imms[2] = 8'hC3; imms[3] = 8'h24;
        idx = 0;
        @(negedge clk);
        bus.cmd_op = OP_LDI; bus.cmd_rd = 2'd0; bus.cmd_rs = 2'd0; bus.cmd_imm = imms[0];
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            if (c != 0) @(negedge clk);
            rdy = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 4) begin
                    bus.cmd_rd  = 2'(idx);
                    bus.cmd_imm = imms[idx];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        bus.cmd_valid = 1'b0;
        vectors++;
        if (idx !== 4) begin
            miscompares++;
            $display("FAIL b2b_count: %0d acceptances, required 4", idx);
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 2) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles, required 2", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        for (int i = 0; i < 4; i++) sb_q.push_back(imms[i]);
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), got, lat);
            exp = sb_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b_r%0d: got %h, required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_swp();
        int acc, lat;
        logic [7:0] got, exp;
        send_cmd(OP_LDI, 2'd1, 2'd0, 8'h66, acc);
        send_cmd(OP_LDI, 2'd2, 2'd0, 8'h99, acc);
        send_cmd(OP_SWP, 2'd1, 2'd2, 8'h00, acc);
        // Three more edges put the sequencer in W_B
        repeat (3) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        vectors++;
        if (bus.rf_crw !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_outputs: crw=%b ready=%b, required 0 1", bus.rf_crw, bus.cmd_ready);
        end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        sb_q.push_back(8'h99);
        sb_q.push_back(8'h99);
        read_reg(2'd1, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL abort_rd_written: R1 got %h, required %h", got, exp);
        end
        read_reg(2'd2, got, lat);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL abort_rs_unwritten: R2 got %h, required %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_rd();
        test_mov();
        test_swp();
        test_backpressure();
        test_throughput();
        test_reset_mid_swp();
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
